// File: rtl/fft_frame_ctrl.sv
// Fills one FRAME_LEN-word frame into the FFT FIFO, then drains it onto a valid/ready stream with sof/eof.
// First m_valid 2 cycles after drain starts; m_ready stalls land in a 2-entry skid and throttle FIFO reads.
module fft_frame_ctrl #(
  parameter int DATA_W    = 36,
  parameter int CNT_W     = 10,
  parameter int FRAME_LEN = 512
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic [DATA_W-1:0] fifo_dout,
  input  logic              fifo_full,
  input  logic              fifo_empty,
  input  logic [CNT_W-1:0]  fifo_dcount,
  output logic              fifo_wr_en,
  output logic              fifo_rd_en,
  output logic [DATA_W-1:0] m_data,
  output logic              m_valid,
  input  logic              m_ready,
  output logic              m_sof,
  output logic              m_eof,
  output logic [15:0]       frame_cnt,
  output logic              busy,
  output logic              err_ovf,
  output logic              err_unf
);

  localparam int RL_W = CNT_W + 1;
  localparam logic [CNT_W-1:0] LAST_IDX    = CNT_W'(FRAME_LEN - 1);
  localparam logic [RL_W-1:0]  FRAME_WORDS = RL_W'(FRAME_LEN);

  typedef enum logic [1:0] {IDLE, FILL, DRAIN} state_t;

  state_t state, state_nxt;

  logic [RL_W-1:0]              rd_left;
  logic                         rd_inflight;
  logic [1:0][DATA_W-1:0]       skid_mem;
  logic                         skid_wptr;
  logic                         skid_rptr;
  logic [1:0]                   skid_occ;
  logic [CNT_W-1:0]             out_idx;

  logic       pop;
  logic       push;
  logic       eof_xfer;
  logic       wr_en_nxt;
  logic       fill_ovf;
  logic       unf_hit;
  logic [2:0] pending;

  assign m_valid  = (skid_occ != 2'd0);
  assign m_data   = skid_mem[skid_rptr];
  assign m_sof    = m_valid && (out_idx == '0);
  assign m_eof    = m_valid && (out_idx == LAST_IDX);
  assign pop      = m_valid && m_ready;
  assign push     = rd_inflight;
  assign eof_xfer = pop && (out_idx == LAST_IDX);
  assign busy     = (state != IDLE);

  // The slot freed by this cycle's pop is counted, so reads can overlap pops at full rate.
  assign pending = 3'(skid_occ) + 3'(rd_inflight) - 3'(pop);

  always_ff @(posedge clk) begin
    if (!rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt  = state;
    wr_en_nxt  = 1'b0;
    fifo_rd_en = 1'b0;
    fill_ovf   = 1'b0;
    unf_hit    = 1'b0;
    case (state)
      IDLE: begin
        if (en) begin
          state_nxt = FILL;
          wr_en_nxt = 1'b1;
        end
      end
      FILL: begin
        wr_en_nxt = 1'b1;
        if (fifo_dcount == LAST_IDX) begin
          state_nxt = DRAIN;
          wr_en_nxt = 1'b0;
        end else if (fifo_full) begin
          state_nxt = DRAIN;
          wr_en_nxt = 1'b0;
          fill_ovf  = 1'b1;
        end
      end
      DRAIN: begin
        fifo_rd_en = (rd_left != '0) && !fifo_empty && (pending < 3'd2);
        unf_hit    = (rd_left != '0) && fifo_empty && (skid_occ == 2'd0) && !rd_inflight;
        if (eof_xfer) begin
          state_nxt = en ? FILL : IDLE;
          wr_en_nxt = en;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      fifo_wr_en  <= 1'b0;
      rd_left     <= '0;
      rd_inflight <= 1'b0;
      skid_mem    <= '0;
      skid_wptr   <= 1'b0;
      skid_rptr   <= 1'b0;
      skid_occ    <= 2'd0;
      out_idx     <= '0;
      frame_cnt   <= 16'd0;
      err_ovf     <= 1'b0;
      err_unf     <= 1'b0;
    end else begin
      fifo_wr_en  <= wr_en_nxt;
      rd_inflight <= fifo_rd_en;

      if (state == FILL && state_nxt == DRAIN) begin
        rd_left <= FRAME_WORDS;
      end else if (fifo_rd_en) begin
        rd_left <= rd_left - RL_W'(1);
      end

      if (push) begin
        skid_mem[skid_wptr] <= fifo_dout;
        skid_wptr           <= ~skid_wptr;
      end
      if (pop) begin
        skid_rptr <= ~skid_rptr;
        out_idx   <= eof_xfer ? '0 : out_idx + CNT_W'(1);
      end
      skid_occ <= skid_occ + 2'(push) - 2'(pop);

      if (eof_xfer) begin
        frame_cnt <= frame_cnt + 16'd1;
      end
      if (fill_ovf) begin
        err_ovf <= 1'b1;
      end
      if (unf_hit) begin
        err_unf <= 1'b1;
      end
    end
  end

endmodule
